// File: rtl/div_32bit.sv
// Multicycle signed divider using the non-restoring algorithm. It produces one
// quotient bit per clock over WIDTH iterations, then spends one cycle fixing
// the signs. The add and subtract steps share a single (WIDTH+1)-bit adder.
module div_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   rem_r;      // signed partial remainder
  logic [WIDTH:0]   div_r;      // |divisor|, zero-extended
  logic [WIDTH-1:0] quo_r;      // |dividend| shifting out, quotient shifting in
  logic [CW-1:0]    cnt_r;
  logic             sign_a_r;
  logic             sign_b_r;
  logic             zero_r;
  logic             ovf_r;

  logic [WIDTH:0]   add_a_s;
  logic             sub_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] quo_out_s;
  logic [WIDTH-1:0] rem_out_s;

  // Two's-complement magnitude. 0x80000000 maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      abs_val = ~x + ONE;
    end else begin
      abs_val = x;
    end
  endfunction

  // Shared adder. In RUN it adds or subtracts the divisor from the shifted
  // remainder. In FIX it adds the divisor back when the remainder is negative.
  always_comb begin
    add_a_s = rem_r;
    sub_s   = 1'b0;
    if (state_r == RUN) begin
      add_a_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
      sub_s   = ~rem_r[WIDTH];
    end else begin
      add_a_s = rem_r;
      sub_s   = 1'b0;
    end
    sum_s = add_a_s + (div_r ^ {(WIDTH+1){sub_s}}) + {{WIDTH{1'b0}}, sub_s};
  end

  // Sign correction of the final quotient and remainder.
  always_comb begin
    rem_fix_s = rem_r[WIDTH] ? sum_s[WIDTH-1:0] : rem_r[WIDTH-1:0];
    quo_out_s = (sign_a_r ^ sign_b_r) ? (~quo_r + ONE) : quo_r;
    rem_out_s = sign_a_r ? (~rem_fix_s + ONE) : rem_fix_s;
  end

  // Control FSM and datapath registers. A start strobe overrides every state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      rem_r          <= {(WIDTH+1){1'b0}};
      div_r          <= {(WIDTH+1){1'b0}};
      quo_r          <= ZERO;
      cnt_r          <= {CW{1'b0}};
      sign_a_r       <= 1'b0;
      sign_b_r       <= 1'b0;
      zero_r         <= 1'b0;
      ovf_r          <= 1'b0;
      data_result    <= ZERO;
      data_remainder <= ZERO;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_DIV) begin
      state_r        <= RUN;
      rem_r          <= {(WIDTH+1){1'b0}};
      div_r          <= {1'b0, abs_val(data_operandB)};
      // On divide-by-zero the raw dividend is kept because it becomes the remainder.
      quo_r          <= (data_operandB == ZERO) ? data_operandA : abs_val(data_operandA);
      cnt_r          <= {CW{1'b0}};
      sign_a_r       <= data_operandA[WIDTH-1];
      sign_b_r       <= data_operandB[WIDTH-1];
      zero_r         <= (data_operandB == ZERO);
      ovf_r          <= (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          data_resultRDY <= 1'b0;
        end
        RUN: begin
          if (zero_r || ovf_r) begin
            data_result    <= zero_r ? ZERO : MIN_NEG;
            data_remainder <= zero_r ? quo_r : ZERO;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state_r        <= DONE;
          end else begin
            rem_r <= sum_s;
            quo_r <= {quo_r[WIDTH-2:0], ~sum_s[WIDTH]};
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CNT_LAST) begin
              state_r <= FIX;
            end else begin
              state_r <= RUN;
            end
          end
        end
        FIX: begin
          rem_r          <= {1'b0, rem_fix_s};
          data_result    <= quo_out_s;
          data_remainder <= rem_out_s;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state_r        <= DONE;
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// Scoreboard testbench for div_32bit. The driver pushes the expected result
// and the completion cycle. The monitor pops the entry and compares it on each
// ready pulse.
module tb_div_32bit;

  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  div_32bit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges so that completion latency can be checked.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model based on signed arithmetic. Integer division truncates
  // toward zero, and the remainder takes the sign of the dividend.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic e);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q = 32'(la / lb);
      r = 32'(la % lb);
      e = 1'b0;
    end
  endtask

  // Pulse the start strobe for one edge and queue the expected response.
  // The task is entered at a negedge and returns at the following negedge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    model(a, b, x.q, x.r, x.e);
    x.cyc = cyc + (x.e ? 2 : 34);
    sb.push_back(x);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    start(a, b);
    wait_idle();
  endtask

  // Monitor: compare each ready pulse with the oldest pending expectation.
  always @(negedge clock) begin
    exp_t x;
    if (reset_n && data_resultRDY) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdy: got ready=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        x = sb.pop_front();
        chk("result",    data_result,    x.q);
        chk("remainder", data_remainder, x.r);
        chk("exception", {31'd0, data_exception}, {31'd0, x.e});
        chk("latency",   32'(cyc),       32'(x.cyc));
        chk("busy_at_rdy", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    int c0;
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #3;
    chk("reset_result", data_result,    32'd0);
    chk("reset_rem",    data_remainder, 32'd0);
    chk("reset_flags",  {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 100/7, with busy checked over the whole operation
    start(32'd100, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      chk("busy_window", {31'd0, busy}, {31'd0, (k <= 33)});
      @(negedge clock);
    end
    wait_idle();

    // signs and edge values
    run_op(-32'sd100, 32'd7);
    run_op(32'd100, -32'sd7);
    run_op(-32'sd100, -32'sd7);
    run_op(32'h7FFF_FFFF, 32'd1);
    run_op(32'h8000_0000, 32'd2);
    run_op(32'd0, 32'd5);
    run_op(32'd5, 32'd9);
    run_op(32'h8000_0000, 32'h8000_0000);
    run_op(32'h7FFF_FFFF, 32'h8000_0000);
    // exceptions, then a normal op that must clear the flag
    run_op(32'd42, 32'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd100, 32'd7);
    // the flag must stay held after the completion pulse
    run_op(32'd9, 32'd0);
    repeat (3) @(negedge clock);
    chk("exc_held", {31'd0, data_exception}, 32'd1);

    // restart 10 edges into an operation: the first result must never appear
    start(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    void'(sb.pop_back());
    run_op(32'd81, 32'd9);

    // asynchronous reset part-way through an operation
    start(32'd1000, 32'd3);
    repeat (19) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_result", data_result,    32'd0);
    chk("async_rst_rem",    data_remainder, 32'd0);
    chk("async_rst_flags",  {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_op(32'd50, 32'd5);

    // randomized operands across magnitude classes
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 400) - 200; b = $urandom_range(1, 30); end
        2: begin a = $urandom; b = $urandom_range(1, 50) * (($urandom_range(0, 1) == 1) ? -1 : 1); end
        default: begin a = $urandom; b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(a, b);
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
